cmp_sweep_ctrl: RTL and testbench
=================================

Name: cmp_sweep_ctrl

Overview:
Self-test sequencer for the 2-bit magnitude comparator that drives the RGB LED. The comparator rule is red = a>b, green = a==b, blue = a<b.
- On start, the block steps through all 16 (a,b) operand pairs in order.
- It holds each pair for a programmable dwell, then samples the comparator's red/green/blue outputs.
- It tallies each colour and flags the first vector whose result differs from the expected value.
- It sits between the board's start/hold buttons and the comparator instance, replacing the manual switch sweep.

Parameters:
DWELL_CYCLES, 4, cycles each operand pair is driven before sampling; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; level-sampled, honoured only in IDLE or DONE
hold  input  1  pause; freezes dwell counter while in DRIVE
a_out  output  2  operand a to comparator
b_out  output  2  operand b to comparator
red_in  input  1  comparator red (a>b)
green_in  input  1  comparator green (a==b)
blue_in  input  1  comparator blue (a<b)
busy  output  1  high in DRIVE or SAMPLE
done  output  1  high in DONE
mismatch  output  1  sticky: at least one vector failed this sweep
err_idx  output  4  index of first failing vector; valid when mismatch=1
red_cnt  output  5  number of samples with red_in=1
green_cnt  output  5  number of samples with green_in=1
blue_cnt  output  5  number of samples with blue_in=1

Behaviour:
- Reset: state=IDLE. All outputs 0, internal idx=0, dwell counter=0. Reset mid-sweep aborts immediately, with no partial results retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- Operand mapping: vector index idx[3:0] gives a_out=idx[3:2], b_out=idx[1:0].
  - Driven in DRIVE and SAMPLE.
  - a_out/b_out = 0 in IDLE and DONE.
- IDLE/DONE with start=1, on the next edge:
  - idx=0, all counts=0, mismatch=0, err_idx=0.
  - dwell counter=DWELL_CYCLES-1, state goes to DRIVE.
  - start=0 leaves the state unchanged, and DONE holds its results.
- DRIVE:
  - Dwell counter at 0: go to SAMPLE.
  - Otherwise: decrement, unless hold=1 (then the counter holds).
  - hold has no effect in any other state.
- SAMPLE (exactly one cycle):
  - Each *_cnt increments if its *_in=1. Several may increment together; none increment if all inputs are 0.
  - Expected = one-hot {a>b, a==b, a<b}. Mismatch condition: {red_in,green_in,blue_in} != expected, which covers wrong colour, none-hot and multi-hot.
  - On mismatch with mismatch=0: set mismatch=1 and err_idx=idx. Later failures leave err_idx unchanged.
  - idx==15: go to DONE. Otherwise idx++, reload dwell counter to DWELL_CYCLES-1, go to DRIVE.
- start while busy is ignored.
- Latency without hold: done rises 16*(DWELL_CYCLES+1) cycles after the edge that registers start, which is 80 cycles at the default.
  - Each hold cycle in DRIVE adds 1 cycle.
- Counts are 5 bits, so the maximum of 16 cannot overflow. Correct comparator totals are red=6, green=4, blue=6.
- All outputs are registered, with no combinational path from *_in to any output.

Test Plan:
1. Correct comparator model, DWELL_CYCLES=4, pulse start -> busy during the sweep; done=1 exactly 80 cycles after the start edge; red_cnt=6, green_cnt=4, blue_cnt=6, mismatch=0.
2. Model with red/blue swapped -> mismatch=1, err_idx=1 (a=0,b=1 expected blue, got red); counts red=6, green=4, blue=6.
3. Model stuck all-zero -> mismatch=1, err_idx=0, all counts 0, done still asserts at 80 cycles.
4. hold=1 for 10 cycles during vector 5's DRIVE -> a_out=1, b_out=1 stays stable throughout; done at 90 cycles; counts unchanged from scenario 1.
5. Assert rst during vector 9 -> next cycle IDLE with all outputs 0. Then pulse start -> full clean sweep identical to scenario 1.
6. start pulsed while busy -> ignored. start in DONE -> counts clear and a new sweep begins; DWELL_CYCLES=1 sweep -> done at 32 cycles.

Source files
------------

// File: rtl/cmp_sweep_ctrl_if.sv
// Bundle between the comparator self-test sequencer and its environment (buttons + comparator).
// master = sequencer side, slave = buttons/comparator side.
interface cmp_sweep_ctrl_if;
    logic       start;
    logic       hold;
    logic [1:0] a_out;
    logic [1:0] b_out;
    logic       red_in;
    logic       green_in;
    logic       blue_in;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic [3:0] err_idx;
    logic [4:0] red_cnt;
    logic [4:0] green_cnt;
    logic [4:0] blue_cnt;

    modport master (
        input  start, hold, red_in, green_in, blue_in,
        output a_out, b_out, busy, done, mismatch, err_idx,
               red_cnt, green_cnt, blue_cnt
    );

    modport slave (
        output start, hold, red_in, green_in, blue_in,
        input  a_out, b_out, busy, done, mismatch, err_idx,
               red_cnt, green_cnt, blue_cnt
    );
endinterface

// File: rtl/cmp_sweep_ctrl.sv
// Sweeps all 16 operand pairs into the 2-bit comparator, samples its RGB result after a dwell,
// tallies colours and latches the first failing vector. Done 16*(DWELL_CYCLES+1) cycles after start; hold stretches DRIVE.
module cmp_sweep_ctrl #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    cmp_sweep_ctrl_if.master bus
);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q;
    logic [DW-1:0] dwell_q;
    logic [4:0]    red_q, green_q, blue_q;
    logic          mismatch_q;
    logic [3:0]    err_idx_q;
    logic [2:0]    expected;
    logic [2:0]    observed;

    assign expected = {idx_q[3:2] > idx_q[1:0], idx_q[3:2] == idx_q[1:0], idx_q[3:2] < idx_q[1:0]};
    assign observed = {bus.red_in, bus.green_in, bus.blue_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = DRIVE;
            DRIVE:      if (dwell_q == '0) state_d = SAMPLE;
            SAMPLE:     state_d = (idx_q == 4'd15) ? DONE : DRIVE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            dwell_q    <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            mismatch_q <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        idx_q      <= '0;
                        dwell_q    <= DWELL_LOAD;
                        red_q      <= '0;
                        green_q    <= '0;
                        blue_q     <= '0;
                        mismatch_q <= 1'b0;
                        err_idx_q  <= '0;
                    end
                end
                DRIVE: begin
                    if (dwell_q != '0 && !bus.hold) dwell_q <= dwell_q - 1'b1;
                end
                SAMPLE: begin
                    red_q   <= red_q   + 5'(bus.red_in);
                    green_q <= green_q + 5'(bus.green_in);
                    blue_q  <= blue_q  + 5'(bus.blue_in);
                    // Only the first failure is recorded; later ones just keep the flag set.
                    if (observed != expected && !mismatch_q) begin
                        mismatch_q <= 1'b1;
                        err_idx_q  <= idx_q;
                    end
                    if (idx_q != 4'd15) begin
                        idx_q   <= idx_q + 1'b1;
                        dwell_q <= DWELL_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy  = (state_q == DRIVE) || (state_q == SAMPLE);
        bus.done  = (state_q == DONE);
        bus.a_out = bus.busy ? idx_q[3:2] : 2'd0;
        bus.b_out = bus.busy ? idx_q[1:0] : 2'd0;
    end

    assign bus.mismatch  = mismatch_q;
    assign bus.err_idx   = err_idx_q;
    assign bus.red_cnt   = red_q;
    assign bus.green_cnt = green_q;
    assign bus.blue_cnt  = blue_q;
endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Bench for cmp_sweep_ctrl: two instances (dwell 4 and dwell 1) driven from a vector table,
// hand-written reset/hold sequences and randomized faulty-comparator sweeps against a reference model.
module tb_cmp_sweep_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic hold;
    logic sel;
    logic [2:0] resp_tab [16];

    int checks = 0;
    int errors = 0;

    cmp_sweep_ctrl_if bus4 ();
    cmp_sweep_ctrl_if bus1 ();

    cmp_sweep_ctrl #(.DWELL_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.master));
    cmp_sweep_ctrl #(.DWELL_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    assign bus4.start = start & ~sel;
    assign bus4.hold  = hold & ~sel;
    assign bus1.start = start & sel;
    assign bus1.hold  = hold & sel;
    assign {bus4.red_in, bus4.green_in, bus4.blue_in} = resp_tab[{bus4.a_out, bus4.b_out}];
    assign {bus1.red_in, bus1.green_in, bus1.blue_in} = resp_tab[{bus1.a_out, bus1.b_out}];

    logic       o_busy, o_done, o_mis;
    logic [1:0] o_a, o_b;
    logic [3:0] o_err;
    logic [4:0] o_r, o_g, o_bl;
    always_comb begin
        o_busy = sel ? bus1.busy      : bus4.busy;
        o_done = sel ? bus1.done      : bus4.done;
        o_mis  = sel ? bus1.mismatch  : bus4.mismatch;
        o_a    = sel ? bus1.a_out     : bus4.a_out;
        o_b    = sel ? bus1.b_out     : bus4.b_out;
        o_err  = sel ? bus1.err_idx   : bus4.err_idx;
        o_r    = sel ? bus1.red_cnt   : bus4.red_cnt;
        o_g    = sel ? bus1.green_cnt : bus4.green_cnt;
        o_bl   = sel ? bus1.blue_cnt  : bus4.blue_cnt;
    end

    function automatic logic [2:0] good_resp(int i);
        int a = i / 4;
        int b = i % 4;
        return {a > b, a == b, a < b};
    endfunction

    // mode 0 correct, 1 red/blue swapped, 2 stuck at zero, 3 random corruption
    task automatic set_model(input int mode);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] g = good_resp(i);
            case (mode)
                0: resp_tab[i] = g;
                1: resp_tab[i] = {g[0], g[1], g[2]};
                2: resp_tab[i] = 3'b000;
                default: resp_tab[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : g;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one sweep on the selected instance. hs>=0: hold for hl edges starting after edge hs;
    // hs==-2: random hold. glitch>=0: start pulsed while busy.
    task automatic run_sweep(input logic s, input int hs, input int hl, input int glitch,
                             output int lat, output int holds);
        int n = 0;
        int busy_bad = 0;
        int stable_bad = 0;
        holds = 0;
        lat = -1;
        @(negedge clk);
        sel = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("clear_on_start", {o_busy, o_done, o_mis, o_err, o_r, o_g, o_bl}, {1'b1, 1'b0, 1'b0, 4'd0, 15'd0});
        while (n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            if (o_done) begin
                lat = n;
                break;
            end
            if (!o_busy) busy_bad++;
            if (hs >= 0) begin
                hold = (n >= hs) && (n < hs + hl);
                if (n >= hs && n <= hs + hl && (o_a != 2'd1 || o_b != 2'd1)) stable_bad++;
            end else if (hs == -2) begin
                hold = ($urandom_range(0, 3) == 0);
                if (hold) holds++;
            end
            start = (n == glitch);
        end
        hold = 1'b0;
        start = 1'b0;
        check("busy_during_sweep", busy_bad, 0);
        if (hs >= 0) check("operands_stable_in_hold", stable_bad, 0);
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic s;
        int   mode;
        int   hs;
        int   hl;
        int   glitch;
        int   lat;
        int   r, g, b;
        int   mis;
        int   err;
    } vec_t;

    vec_t tab [7];

    task automatic run_row(input vec_t v);
        int lat, holds;
        set_model(v.mode);
        run_sweep(v.s, v.hs, v.hl, v.glitch, lat, holds);
        check("done_latency", lat, v.lat);
        check("red_cnt", o_r, v.r);
        check("green_cnt", o_g, v.g);
        check("blue_cnt", o_bl, v.b);
        check("mismatch", o_mis, v.mis);
        check("err_idx", o_err, v.err);
        check("operands_zero_in_done", {o_a, o_b}, 0);
    endtask

    initial begin
        tab[0] = '{1'b0, 0, -1, 0, -1, 80, 6, 4, 6, 0, 0};
        tab[1] = '{1'b0, 1, -1, 0, -1, 80, 6, 4, 6, 1, 1};
        tab[2] = '{1'b0, 2, -1, 0, -1, 80, 0, 0, 0, 1, 0};
        tab[3] = '{1'b0, 0, 26, 10, -1, 90, 6, 4, 6, 0, 0};
        tab[4] = '{1'b0, 0, -1, 0, 40, 80, 6, 4, 6, 0, 0};
        tab[5] = '{1'b1, 0, -1, 0, 10, 32, 6, 4, 6, 0, 0};
        tab[6] = '{1'b1, 1, -1, 0, -1, 32, 6, 4, 6, 1, 1};

        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        sel = 1'b0;
        set_model(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut4", {bus4.busy, bus4.done, bus4.mismatch, bus4.err_idx, bus4.a_out, bus4.b_out,
                             bus4.red_cnt, bus4.green_cnt, bus4.blue_cnt}, 0);
        check("reset_dut1", {bus1.busy, bus1.done, bus1.mismatch, bus1.err_idx, bus1.a_out, bus1.b_out,
                             bus1.red_cnt, bus1.green_cnt, bus1.blue_cnt}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_row(tab[i]);

        // Reset in the middle of vector 9 on the dwell-4 instance, starting from a failing sweep.
        set_model(1);
        @(negedge clk);
        sel = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (47) @(posedge clk);
        #1;
        check("vector9_operands", {o_a, o_b}, {2'd2, 2'd1});
        check("partial_mismatch", o_mis, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midsweep_reset", {o_busy, o_done, o_mis, o_err, o_a, o_b, o_r, o_g, o_bl}, 0);
        run_row(tab[0]);

        // Randomized comparator faults and hold patterns against the reference model.
        for (int it = 0; it < 8; it++) begin
            int lat, holds, er, eg, eb, emis, eerr, base;
            logic s = 1'($urandom_range(0, 1));
            set_model(3);
            er = 0; eg = 0; eb = 0; emis = 0; eerr = 0;
            for (int i = 0; i < 16; i++) begin
                er += resp_tab[i][2];
                eg += resp_tab[i][1];
                eb += resp_tab[i][0];
                if (resp_tab[i] != good_resp(i) && emis == 0) begin
                    emis = 1;
                    eerr = i;
                end
            end
            base = s ? 32 : 80;
            run_sweep(s, -2, 0, -1, lat, holds);
            check("rnd_latency_min", (lat >= base), 1);
            check("rnd_latency_max", (lat <= base + holds), 1);
            check("rnd_red", o_r, er);
            check("rnd_green", o_g, eg);
            check("rnd_blue", o_bl, eb);
            check("rnd_mismatch", o_mis, emis);
            if (emis != 0) check("rnd_err_idx", o_err, eerr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
